// File: rtl/umem_sched_pkg.sv
// umem_sched_pkg
// Shared definitions for the unified-memory sequencer: the FSM state
// encoding, the cycles-per-instruction constants and the NOP word that the
// held instruction register resets to.
// The DBG/DWAIT states exist only when UMEM_SCHED_DBG_EN is defined.
package umem_sched_pkg;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_LWAIT = 3'd3
`ifdef UMEM_SCHED_DBG_EN
        ,
        S_DBG   = 3'd4,
        S_DWAIT = 3'd5
`endif
    } umemState_e;

    localparam int CPI_ALU  = 3;
    localparam int CPI_LOAD = 4;

    // All-zero word doubles as the NOP so a freshly reset core decodes nothing
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/umem_dbg_port.sv
// umem_dbg_port
// Debug-side memory access mux and read-data return for umem_sched.
// Ports:
//   inDbg_i     - sequencer is in the debug grant cycle (reset already masked)
//   inDwait_i   - sequencer is in the debug read-return cycle
//   dbgWe_i     - debug write (1) or read (0)
//   dbgAddr_i   - debug address
//   dbgWdata_i  - debug write data
//   memRdata_i  - memory read data
//   memRe_o / memWe_o / memAddr_o / memWdata_o - memory request during grant
//   dbgRdata_o  - read data, zero outside the return cycle
module umem_dbg_port #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          inDbg_i,
    input  logic          inDwait_i,
    input  logic          dbgWe_i,
    input  logic [AW-1:0] dbgAddr_i,
    input  logic [DW-1:0] dbgWdata_i,
    input  logic [DW-1:0] memRdata_i,
    output logic          memRe_o,
    output logic          memWe_o,
    output logic [AW-1:0] memAddr_o,
    output logic [DW-1:0] memWdata_o,
    output logic [DW-1:0] dbgRdata_o
);

    // Request is only presented during the grant cycle; read data arrives
    // the cycle after, which is exactly the return cycle.
    always_comb begin
        memRe_o    = inDbg_i & ~dbgWe_i;
        memWe_o    = inDbg_i & dbgWe_i;
        memAddr_o  = inDbg_i ? dbgAddr_i : '0;
        memWdata_o = inDbg_i ? dbgWdata_i : '0;
        dbgRdata_o = inDwait_i ? memRdata_i : '0;
    end

endmodule

// File: rtl/umem_sched.sv
// umem_sched
// Multi-cycle sequencer sharing one single-port memory between instruction
// fetch, data load/store and a debug loader port. Holds the fetched
// instruction for the core and pulses commit in the last cycle of each
// instruction.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cpu_pc/cpu_load/cpu_store/cpu_addr/cpu_wdata - core request side
//   instr, readdata, commit  - held instruction, load data, update enable
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata   - memory port (1-cycle read)
//   dbg_req/dbg_we/dbg_addr/dbg_wdata            - debug request
//   dbg_gnt/dbg_rvalid/dbg_rdata                 - debug response
// Configuration: define UMEM_SCHED_DBG_EN to build the debug port; otherwise
// dbg_req is ignored and the debug outputs are held at zero.
module umem_sched
    import umem_sched_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_pc,
    input  logic          cpu_load,
    input  logic          cpu_store,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] readdata,
    output logic          commit,
    output logic          mem_re,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata
);

    umemState_e    state_q;
    logic [DW-1:0] instr_q;
    logic          dbgTake;

`ifdef UMEM_SCHED_DBG_EN
    logic          inDbg;
    logic          inDwait;
    logic          dbgMemRe;
    logic          dbgMemWe;
    logic [AW-1:0] dbgMemAddr;
    logic [DW-1:0] dbgMemWdata;

    assign inDbg   = ~rst && (state_q == S_DBG);
    assign inDwait = ~rst && (state_q == S_DWAIT);
    assign dbgTake = dbg_req;

    umem_dbg_port #(.AW(AW), .DW(DW)) u_dbg (
        .inDbg_i    (inDbg),
        .inDwait_i  (inDwait),
        .dbgWe_i    (dbg_we),
        .dbgAddr_i  (dbg_addr),
        .dbgWdata_i (dbg_wdata),
        .memRdata_i (mem_rdata),
        .memRe_o    (dbgMemRe),
        .memWe_o    (dbgMemWe),
        .memAddr_o  (dbgMemAddr),
        .memWdata_o (dbgMemWdata),
        .dbgRdata_o (dbg_rdata)
    );

    assign dbg_gnt    = inDbg;
    assign dbg_rvalid = inDwait;
`else
    assign dbgTake    = 1'b0;
    assign dbg_gnt    = 1'b0;
    assign dbg_rvalid = 1'b0;
    assign dbg_rdata  = '0;
    wire unusedDbg = &{1'b0, dbg_req, dbg_we, dbg_addr, dbg_wdata};
`endif

    // Sequencer state and the held instruction. Debug is only taken from
    // FETCH so a CPU instruction is never split by a debug access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            instr_q <= DW'(NOP_INSTR);
        end else begin
            case (state_q)
                S_FETCH: state_q <= dbgTake ? 
`ifdef UMEM_SCHED_DBG_EN
                                    S_DBG
`else
                                    S_FETCH
`endif
                                    : S_FWAIT;
                S_FWAIT: begin
                    instr_q <= mem_rdata;
                    state_q <= S_EXEC;
                end
                S_EXEC:  state_q <= cpu_load ? S_LWAIT : S_FETCH;
                S_LWAIT: state_q <= S_FETCH;
`ifdef UMEM_SCHED_DBG_EN
                S_DBG:   state_q <= dbg_we ? S_FETCH : S_DWAIT;
                S_DWAIT: state_q <= S_FETCH;
`endif
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign instr = instr_q;

    // Memory strobes and commit follow the current state within the same
    // cycle; reset masks them all so an in-flight store is never written.
    // Load wins over store when the decoder flags both.
    always_comb begin
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        commit    = 1'b0;
        readdata  = '0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if (!dbgTake) begin
                        mem_re   = 1'b1;
                        mem_addr = cpu_pc;
                    end
                end
                S_EXEC: begin
                    if (cpu_load) begin
                        mem_re   = 1'b1;
                        mem_addr = cpu_addr;
                    end else if (cpu_store) begin
                        mem_we    = 1'b1;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        commit    = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
                S_LWAIT: begin
                    readdata = mem_rdata;
                    commit   = 1'b1;
                end
`ifdef UMEM_SCHED_DBG_EN
                S_DBG: begin
                    mem_re    = dbgMemRe;
                    mem_we    = dbgMemWe;
                    mem_addr  = dbgMemAddr;
                    mem_wdata = dbgMemWdata;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
